// File: rtl/adder_share_sequencer.sv
// Two-requester adder that time-shares one 4-bit ripple-carry adder, one nibble per cycle.
// Optional macro ROUND_ROBIN_EN: round-robin arbitration instead of fixed priority to requester 0.
`timescale 1ns/1ps

module bit_ripple_carry_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] c;

  assign c[0] = cin_i;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[4];
endmodule

module adder_share_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid0,
  input  logic             req_valid1,
  output logic             req_ready0,
  output logic             req_ready1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             Cin0,
  input  logic             Cin1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic [1:0]       dbg_state_o
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready* is a combinational grant in IDLE; rsp_valid holds until rsp_ready.
  localparam int NW = WIDTH / 4;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q, id_q, rsp_valid_q;
  logic [CW-1:0]    nib_q;
  logic             gnt_any, gnt_id, accept;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cin, add_cout;
`ifdef ROUND_ROBIN_EN
  logic             last_q;
`endif

  always_comb begin
    gnt_any = req_valid0 | req_valid1;
`ifdef ROUND_ROBIN_EN
    // On contention, favour whoever was not granted last.
    if (req_valid0 && req_valid1) gnt_id = ~last_q;
    else                          gnt_id = ~req_valid0;
`else
    gnt_id = ~req_valid0;
`endif
  end

  assign accept     = (state_q == IDLE) && !rst && gnt_any;
  assign req_ready0 = accept && !gnt_id;
  assign req_ready1 = accept && gnt_id;

  // The shared adder sees zeros whenever no nibble is being processed.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[{nib_q, 2'b00} +: 4];
      add_b   = b_q[{nib_q, 2'b00} +: 4];
      add_cin = carry_q;
    end
  end

  bit_ripple_carry_adder u_adder (
    .a_i   (add_a),
    .b_i   (add_b),
    .cin_i (add_cin),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      id_q        <= 1'b0;
      nib_q       <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= gnt_id ? A1 : A0;
            b_q     <= gnt_id ? B1 : B0;
            carry_q <= gnt_id ? Cin1 : Cin0;
            id_q    <= gnt_id;
            nib_q   <= '0;
            state_q <= RUN;
`ifdef ROUND_ROBIN_EN
            last_q  <= gnt_id;
`endif
          end
        end
        RUN: begin
          sum_q[{nib_q, 2'b00} +: 4] <= add_sum;
          carry_q                    <= add_cout;
          if (nib_q == LAST_NIB) begin
            nib_q       <= '0;
            cout_q      <= add_cout;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            nib_q <= nib_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_adder_share_sequencer.sv
// Directed bench for adder_share_sequencer (WIDTH=16): vector table plus reset, contention,
// backpressure and mid-operation reset sequences.
`timescale 1ns/1ps

module tb_adder_share_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid0, req_valid1, req_ready0, req_ready1;
  logic [W-1:0] A0, B0, A1, B1, Sum;
  logic         Cin0, Cin1, rsp_valid, rsp_ready, rsp_id, Cout;
  logic [1:0]   dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  adder_share_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid0 (req_valid0),
    .req_valid1 (req_valid1),
    .req_ready0 (req_ready0),
    .req_ready1 (req_ready1),
    .A0         (A0),
    .B0         (B0),
    .A1         (A1),
    .B1         (B1),
    .Cin0       (Cin0),
    .Cin1       (Cin1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .Sum        (Sum),
    .Cout       (Cout),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin);
    if (sel) begin
      req_valid1 = 1'b1; A1 = a; B1 = b; Cin1 = cin;
    end else begin
      req_valid0 = 1'b1; A0 = a; B0 = b; Cin0 = cin;
    end
  endtask

  task automatic scramble_inputs();
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    A0 = W'($urandom); B0 = W'($urandom); Cin0 = 1'($urandom_range(1));
    A1 = W'($urandom); B1 = W'($urandom); Cin1 = 1'($urandom_range(1));
  endtask

  // Full operation: wait for grant, accept, then check latency and result.
  task automatic run_op(input string name, input logic sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] es, input logic ec);
    int  lat;
    bit  got;
    drive_req(sel, a, b, cin);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if ((sel ? req_ready1 : req_ready0) === 1'b1) got = 1;
      else tick();
    end
    check({name, "_grant"}, 32'(got), 32'd1);
    if (!got) begin
      scramble_inputs();
      return;
    end
    tick();
    scramble_inputs();
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_sum"}, 32'(Sum), 32'(es));
    check({name, "_cout"}, 32'(Cout), 32'(ec));
    check({name, "_id"}, 32'(rsp_id), 32'(sel));
    tick();
    check({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_g;
    logic       g;
    int         waitc;
    logic [W-1:0] hold_sum;

    rst = 1'b1; rsp_ready = 1'b1;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    A0 = 16'h1234; B0 = 16'h0FCD; Cin0 = 1'b0;
    A1 = 16'h1111; B1 = 16'h2222; Cin1 = 1'b1;

    // Reset with both requesters asking.
    tick();
    check("rst_ready0", 32'(req_ready0), 32'd0);
    check("rst_ready1", 32'(req_ready1), 32'd0);
    tick();
    check("rst_ready0_b", 32'(req_ready0), 32'd0);
    check("rst_ready1_b", 32'(req_ready1), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_sum", 32'(Sum), 32'h0);
    check("rst_cout", 32'(Cout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    scramble_inputs();
    rst = 1'b0;
    tick();

    vecs[0] = '{"single",   1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0};
    vecs[1] = '{"carry_a",  1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{"carry_b",  1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{"msb_wrap", 1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{"mid_cin",  1'b0, 16'h00F0, 16'h0010, 1'b1, 16'h0101, 1'b0};
    vecs[5] = '{"cin_ripl", 1'b1, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};
    vecs[6] = '{"plain",    1'b0, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].name, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout);

    // Contention: both valid held for three operations.
`ifdef ROUND_ROBIN_EN
    exp_g = 3'b010;
`else
    exp_g = 3'b000;
`endif
    do_reset();
    drive_req(1'b0, 16'h0001, 16'h0001, 1'b0);
    drive_req(1'b1, 16'h0002, 16'h0002, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitc = 0;
      while (!(req_ready0 || req_ready1) && waitc < 10) begin
        tick();
        waitc++;
      end
      check($sformatf("cont_grant_seen%0d", k), 32'(req_ready0 | req_ready1), 32'd1);
      check($sformatf("cont_one_hot%0d", k), 32'(req_ready0 & req_ready1), 32'd0);
      g = req_ready1;
      check($sformatf("cont_grant%0d", k), 32'(g), 32'(exp_g[k]));
      tick();
      check($sformatf("cont_busy_ready%0d", k), 32'(req_ready0 | req_ready1), 32'd0);
      waitc = 0;
      while (rsp_valid !== 1'b1 && waitc < 12) begin
        tick();
        waitc++;
      end
      check($sformatf("cont_id%0d", k), 32'(rsp_id), 32'(exp_g[k]));
      check($sformatf("cont_sum%0d", k), 32'(Sum), exp_g[k] ? 32'h4 : 32'h2);
      tick();
    end
    scramble_inputs();
    tick();

    // Backpressure: hold the result while rsp_ready is low.
    rsp_ready = 1'b0;
    drive_req(1'b1, 16'h1000, 16'h0234, 1'b1);
    waitc = 0;
    while (req_ready1 !== 1'b1 && waitc < 10) begin
      tick();
      waitc++;
    end
    tick();
    waitc = 0;
    while (rsp_valid !== 1'b1 && waitc < 12) begin
      tick();
      waitc++;
    end
    check("bp_valid", 32'(rsp_valid), 32'd1);
    hold_sum = Sum;
    check("bp_sum", 32'(hold_sum), 32'h1235);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_hold_sum%0d", k), 32'(Sum), 32'h1235);
      check($sformatf("bp_hold_id%0d", k), 32'(rsp_id), 32'd1);
      check($sformatf("bp_hold_cout%0d", k), 32'(Cout), 32'd0);
      check($sformatf("bp_ready%0d", k), 32'(req_ready0 | req_ready1), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_next_ready", 32'(req_ready1), 32'd1);
    tick();
    scramble_inputs();
    waitc = 0;
    while (rsp_valid !== 1'b1 && waitc < 12) begin
      tick();
      waitc++;
    end
    check("bp_second_lat", 32'(waitc), 32'd4);
    check("bp_second_sum", 32'(Sum), 32'h1235);
    tick();

    // Reset during the second nibble of an operation.
    drive_req(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    waitc = 0;
    while (req_ready0 !== 1'b1 && waitc < 10) begin
      tick();
      waitc++;
    end
    tick();
    scramble_inputs();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    g = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid === 1'b1) g = 1'b1;
      tick();
    end
    check("mid_rst_no_rsp", 32'(g), 32'd0);
    run_op("after_rst", 1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/adder_share_sequencer.md
ADDER_SHARE_SEQUENCER -- requirements
Module: adder_share_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; WIDTH SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports req_valid0, req_valid1  input  1 each  requester 0/1 has an operation pending.
REQ-005 SHALL have ports req_ready0, req_ready1  output  1 each  requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports A0, B0, A1, B1  input  WIDTH each  operands of requester 0/1.
REQ-007 SHALL have ports Cin0, Cin1  input  1 each  carry-in of requester 0/1.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port Sum  output  WIDTH  result sum.
REQ-012 SHALL have port Cout  output  1  result carry-out.

Function
REQ-013 SHALL compute {Cout,Sum} = A + B + Cin over WIDTH bits through one shared instance of the team's 4-bit ripple-carry adder bit_ripple_carry_adder, one nibble per cycle, LSB nibble first.
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on acceptance; RUN->DONE after WIDTH/4 nibble cycles; DONE->IDLE on rsp_valid && rsp_ready.
REQ-015 SHALL drive req_ready0/1 only in IDLE, combinationally, to at most one requester (the grant), and only when that requester's req_valid is high.
REQ-016 SHALL capture A, B, Cin of the granted requester and its index at the acceptance edge; later input changes SHALL have no effect on the operation.
REQ-017 SHALL, in RUN, feed nibble k of the captured operands and a registered carry (captured Cin for k=0) to the adder, store its Sum into result nibble k and its Cout into the carry register.
REQ-018 SHALL assert rsp_valid exactly WIDTH/4 cycles after the acceptance edge (4 cycles for WIDTH=16) and hold Sum, Cout, rsp_id stable while rsp_valid && !rsp_ready.
REQ-019 SHALL deassert rsp_valid the cycle after the rsp_valid && rsp_ready handshake; a new acceptance SHALL occur no earlier than that IDLE cycle (no overlap).
REQ-020 SHALL discard the final carry only via Cout; Sum SHALL wrap modulo 2^WIDTH.
REQ-021 SHALL hold the shared adder inputs at zero outside RUN.

Reset
REQ-022 SHALL, on rst high at a rising edge, enter IDLE, clear rsp_valid, Sum, Cout, rsp_id, carry and nibble counter to 0, and reset the arbitration pointer so requester 0 wins the next contention.
REQ-023 SHALL hold req_ready0/1 low while rst is high.
REQ-024 SHALL abandon any in-progress RUN or DONE operation on rst, with no response ever issued for it.

Configuration
REQ-025 SHALL, with ROUND_ROBIN_EN defined, grant the requester not granted last when both req_valid are high in IDLE, updating the pointer only on acceptance.
REQ-026 SHALL, without ROUND_ROBIN_EN, grant requester 0 whenever req_valid0 is high (fixed priority), with no pointer state.
REQ-027 SHALL behave identically in both builds when at most one req_valid is high.

Verification
REQ-028 Reset: rst high 2 cycles with both req_valid high -> req_ready0/1 = 0, rsp_valid = 0, Sum = 0x0000, Cout = 0.
REQ-029 Single op (WIDTH=16): req0 A0=0x1234, B0=0x0FCD, Cin0=0, rsp_ready=1 -> rsp_valid 4 cycles after acceptance, Sum=0x2201, Cout=0, rsp_id=0.
REQ-030 Carry chain: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1; A=0xFFFF, B=0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1.
REQ-031 Contention: both req_valid held high for 3 operations -> with ROUND_ROBIN_EN grants 0,1,0; without it grants 0,0,0.
REQ-032 Backpressure: rsp_ready low 3 cycles after rsp_valid -> Sum/Cout/rsp_id stable, req_ready0/1 = 0; rsp_ready high -> rsp_valid low and next request accepted the following cycle.
REQ-033 Reset mid-operation: rst pulsed during second RUN nibble of 0x1234+0x0FCD -> IDLE next cycle, rsp_valid never asserted for that op, next req1 op (0x0001+0x0002) returns Sum=0x0003, rsp_id=1.
